// File: rtl/mem_access_if.sv
// Data-bus interface between the memory-access stage (master) and data memory (slave).
interface mem_access_if #(
  parameter int unsigned XLEN = 32
);

  logic            dbus_req;
  logic            dbus_we;
  logic [XLEN-1:0] dbus_addr;
  logic [XLEN-1:0] dbus_wdata;
  logic [3:0]      dbus_be;
  logic            dbus_gnt;
  logic            dbus_rvalid;
  logic [XLEN-1:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_gnt, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_gnt, dbus_rvalid, dbus_rdata
  );

endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs one load/store at a time over a
// request/grant/response bus, stalls upstream while busy, and hands aligned,
// extended load data (or the passed-through ALU result) to writeback.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses with a one-cycle misalign pulse instead of a bus access.
module mem_access #(
  parameter  int unsigned BUS_TIMEOUT = 255,
  localparam int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_funct,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] rs2_data_out,
  input  logic [4:0]      rd_in,
  input  logic            rd_we_in,
  output logic            mem_stall,
  mem_access_if.master    bus,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            bus_err,
  output logic            misalign
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        be_q;
  logic [2:0]        funct_q;
  logic [1:0]        off_q;
  logic              load_q;
  logic [4:0]        rd_q;
  logic              rd_we_q;

  logic              is_mem_c;
  logic              misaligned_c;
  logic              timeout_hit_c;
  logic              accept_c;
  logic              alu_c;
  logic              misal_c;
  logic              done_c;
  logic              timeout_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c;
  logic [7:0]        lane_b_c;
  logic [15:0]       lane_h_c;
  logic [XLEN-1:0]   load_c;

  assign is_mem_c      = mem_read | mem_write;
  assign timeout_hit_c = (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned_c = ((mem_funct[1:0] == 2'b01) && result[0]) ||
                        (mem_funct[1] && (result[1:0] != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  assign bus.dbus_req   = req_q;
  assign bus.dbus_we    = we_q;
  assign bus.dbus_addr  = addr_q;
  assign bus.dbus_wdata = wdata_q;
  assign bus.dbus_be    = be_q;

  // Byte enables and lane-replicated store data for the incoming op
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = rs2_data_out;
    case (mem_funct[1:0])
      2'b00: begin
        be_c    = 4'b0001 << result[1:0];
        wdata_c = {4{rs2_data_out[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {result[1], 1'b0};
        wdata_c = {2{rs2_data_out[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of returned load data
  always_comb begin
    lane_b_c = bus.dbus_rdata[7:0];
    case (off_q)
      2'b01:   lane_b_c = bus.dbus_rdata[15:8];
      2'b10:   lane_b_c = bus.dbus_rdata[23:16];
      2'b11:   lane_b_c = bus.dbus_rdata[31:24];
      default: lane_b_c = bus.dbus_rdata[7:0];
    endcase
    lane_h_c = off_q[1] ? bus.dbus_rdata[31:16] : bus.dbus_rdata[15:0];
    case (funct_q[1:0])
      2'b00:   load_c = funct_q[2] ? {24'd0, lane_b_c} : {{24{lane_b_c[7]}}, lane_b_c};
      2'b01:   load_c = funct_q[2] ? {16'd0, lane_h_c} : {{16{lane_h_c[15]}}, lane_h_c};
      default: load_c = bus.dbus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, stall and event decode
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    accept_c  = 1'b0;
    alu_c     = 1'b0;
    misal_c   = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (!is_mem_c) begin
            alu_c = 1'b1;
          end else if (misaligned_c) begin
            misal_c = 1'b1;
          end else begin
            accept_c  = 1'b1;
            mem_stall = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (timeout_hit_c) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else if (bus.dbus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.dbus_rvalid) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          mem_stall = 1'b1;
          if (timeout_hit_c) begin
            timeout_c = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request registers, latched op context and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      funct_q <= '0;
      off_q   <= '0;
      load_q  <= 1'b0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else begin
      if (state_q != IDLE) cnt_q <= cnt_q + CNT_W'(1);
      if (accept_c) begin
        cnt_q   <= '0;
        req_q   <= 1'b1;
        we_q    <= mem_write;
        addr_q  <= {result[XLEN-1:2], 2'b00};
        wdata_q <= wdata_c;
        be_q    <= be_c;
        funct_q <= mem_funct;
        off_q   <= result[1:0];
        load_q  <= mem_read;
        rd_q    <= rd_in;
        rd_we_q <= rd_we_in;
      end
      if ((state_q == REQ && bus.dbus_gnt) || timeout_c) req_q <= 1'b0;
    end
  end

  // Writeback and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      bus_err  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= timeout_c;
      misalign <= misal_c;
      if (alu_c) begin
        wb_valid <= 1'b1;
        wb_data  <= result;
        wb_rd    <= rd_in;
        wb_we    <= rd_we_in;
      end else if (done_c && load_q) begin
        wb_valid <= 1'b1;
        wb_data  <= load_c;
        wb_rd    <= rd_q;
        wb_we    <= rd_we_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: randomized loads/stores/ALU ops against a
// byte-lane reference model, with a bus responder and decoupled monitors.
module tb_mem_access;

  localparam int unsigned TO = 8;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [2:0]  flags;   // {wb_valid, bus_err, misalign}
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } out_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [2:0]  mem_funct;
  logic [31:0] result, rs2_data_out;
  logic [4:0]  rd_in;
  logic        rd_we_in;
  logic        mem_stall;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_err, misalign;

  mem_access_if bus();

  mem_access #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_funct(mem_funct), .result(result), .rs2_data_out(rs2_data_out),
    .rd_in(rd_in), .rd_we_in(rd_we_in), .mem_stall(mem_stall),
    .bus(bus),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int last_evt_cyc = 0;

  bus_exp_t bq[$];
  out_exp_t oq[$];

  int          gnt_dly = 0;
  int          rv_dly  = 0;
  logic [31:0] rsp_rdata = '0;
  bit          rsp_never = 1'b0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: byte-lane arithmetic on the 32-bit word
  function automatic logic [3:0] exp_be(logic [2:0] f, logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (f[1:0] == 2'b00) return 4'(1 << off);
    if (f[1:0] == 2'b01) return 4'(3 << (off & 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f, logic [31:0] d);
    if (f[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (f[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] a, logic [31:0] w);
    int unsigned sh;
    logic [31:0] v;
    if (f[1:0] == 2'b00) begin
      sh = 8 * (a % 4);
      v = (w >> sh) & 32'hFF;
      if (!f[2] && v >= 32'h80) v = v - 32'h100;
    end else if (f[1:0] == 2'b01) begin
      sh = 16 * ((a % 4) / 2);
      v = (w >> sh) & 32'hFFFF;
      if (!f[2] && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic bit exp_misal(logic [2:0] f, logic [31:0] a);
    return ((f[1:0] == 2'b01) && (a % 2 != 0)) || ((f[1:0] == 2'b10) && (a % 4 != 0));
  endfunction

  // Bus responder: grant after gnt_dly cycles, respond rv_dly cycles later
  initial begin
    bus.dbus_gnt    = 1'b0;
    bus.dbus_rvalid = 1'b0;
    bus.dbus_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.dbus_req === 1'b1) begin
        if (rsp_never) begin
          repeat (TO + 2) begin @(posedge clk); #1; end
          bus.dbus_rvalid = 1'b1;
          bus.dbus_rdata  = $urandom;
          @(posedge clk); #1;
          bus.dbus_rvalid = 1'b0;
        end else begin
          repeat (gnt_dly) begin @(posedge clk); #1; end
          bus.dbus_gnt = 1'b1;
          @(posedge clk); #1;
          bus.dbus_gnt = 1'b0;
          repeat (rv_dly) begin @(posedge clk); #1; end
          bus.dbus_rvalid = 1'b1;
          bus.dbus_rdata  = rsp_rdata;
          @(posedge clk); #1;
          bus.dbus_rvalid = 1'b0;
          bus.dbus_rdata  = $urandom;
        end
      end
    end
  end

  // Bus monitor: checks each new request and its stability while held
  initial begin
    bit       prev_req = 1'b0;
    bit       have_cur = 1'b0;
    bus_exp_t cur;
    forever begin
      @(negedge clk);
      if (bus.dbus_req === 1'b1) begin
        if (!prev_req) begin
          if (bq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got addr 0x%0h expected no request", bus.dbus_addr);
            have_cur = 1'b0;
          end else begin
            cur = bq.pop_front();
            have_cur = 1'b1;
            check("req_addr", bus.dbus_addr, cur.addr);
            check("req_we", 32'(bus.dbus_we), 32'(cur.we));
            check("req_be", 32'(bus.dbus_be), 32'(cur.be));
            if (cur.we) check("req_wdata", bus.dbus_wdata, cur.wdata);
          end
        end else if (have_cur) begin
          check("req_stable",
                32'(bus.dbus_addr == cur.addr && bus.dbus_be == cur.be && bus.dbus_we == cur.we &&
                    (!cur.we || bus.dbus_wdata == cur.wdata)), 32'd1);
        end
      end
      prev_req = (bus.dbus_req === 1'b1);
    end
  end

  // Output monitor: every writeback/error pulse pops one expectation
  initial begin
    out_exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid || bus_err || misalign) begin
        last_evt_cyc = cyc;
        if (oq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got flags %b data 0x%0h expected none",
                   {wb_valid, bus_err, misalign}, wb_data);
        end else begin
          e = oq.pop_front();
          check("out_flags", 32'({wb_valid, bus_err, misalign}), 32'(e.flags));
          if (e.flags == 3'b100) begin
            check("wb_data", wb_data, e.data);
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_we", 32'(wb_we), 32'(e.we));
          end
        end
      end
    end
  end

  // Issue one op from an IDLE cycle start; returns stall cycles and output latency
  task automatic do_op(input bit rd_op, input bit wr_op, input logic [2:0] f,
                       input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input bit rdwe, input logic [31:0] rdata,
                       input int gd, input int rvd, input bit has_exp, input logic [31:0] exp_val,
                       output int stall_n, output int lat);
    bit       is_mem, misal, done;
    bus_exp_t bx;
    int       acc;
    is_mem = rd_op | wr_op;
    misal  = MIS_EN && is_mem && exp_misal(f, res);
    gnt_dly = gd; rv_dly = rvd; rsp_rdata = rdata;
    if (is_mem && !misal) begin
      bx.addr = res & 32'hFFFF_FFFC; bx.we = wr_op;
      bx.be = exp_be(f, res); bx.wdata = exp_wdata(f, sd);
      bq.push_back(bx);
    end
    if (misal)       oq.push_back('{3'b001, 32'd0, 5'd0, 1'b0});
    else if (!is_mem) oq.push_back('{3'b100, res, rd, rdwe});
    else if (rd_op)  oq.push_back('{3'b100, has_exp ? exp_val : exp_load(f, res, rdata), rd, rdwe});
    mem_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; mem_funct = f;
    result = res; rs2_data_out = sd; rd_in = rd; rd_we_in = rdwe;
    acc = cyc;
    @(negedge clk);
    check("stall_accept", 32'(mem_stall), 32'(is_mem && !misal));
    stall_n = mem_stall ? 1 : 0;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    result = $urandom; rs2_data_out = $urandom;
    done = 1'b0;
    for (int i = 0; i < int'(TO) + 50 && !done; i++) begin
      @(negedge clk);
      if (mem_stall) stall_n++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL op_complete: got stall still high expected release within %0d cycles", TO + 50);
    end
    @(negedge clk);
    @(posedge clk); #1;
    lat = last_evt_cyc - acc;
  endtask

  initial begin
    int sn, lt, k, gd, rvd;
    logic [2:0]  f;
    logic [31:0] a;
    bit rdop, wrop, mis;
    rst = 1'b1; mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_funct = '0; result = '0; rs2_data_out = '0; rd_in = '0; rd_we_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_req", 32'(bus.dbus_req), 32'd0);
    check("rst_be", 32'(bus.dbus_be), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW, immediate grant and response
    do_op(1, 0, 3'b010, 32'h100, 32'd0, 5'd3, 1, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, sn, lt);
    check("lw_stall_cycles", 32'(sn), 32'd2);
    check("lw_wb_latency", 32'(lt), 32'd3);
    // LB / LBU / LHU lane extraction
    do_op(1, 0, 3'b000, 32'h103, 32'd0, 5'd4, 1, 32'h80FF_0000, 0, 1, 1, 32'hFFFF_FF80, sn, lt);
    do_op(1, 0, 3'b100, 32'h103, 32'd0, 5'd5, 1, 32'h80FF_0000, 1, 0, 1, 32'h0000_0080, sn, lt);
    do_op(1, 0, 3'b101, 32'h102, 32'd0, 5'd6, 1, 32'h80FF_0000, 0, 0, 1, 32'h0000_80FF, sn, lt);
    // SH with grant delayed 3 cycles
    do_op(0, 1, 3'b001, 32'h206, 32'h1234_ABCD, 5'd9, 1, 32'd0, 3, 0, 0, 32'd0, sn, lt);
    check("sh_stall_cycles", 32'(sn), 32'd5);
    // ALU pass-through
    do_op(0, 0, 3'b000, 32'h55, 32'd0, 5'd7, 1, 32'd0, 0, 0, 0, 32'd0, sn, lt);
    check("alu_stall_cycles", 32'(sn), 32'd0);
    check("alu_wb_latency", 32'(lt), 32'd1);

    // Timeout: no response, late rvalid must be ignored
    rsp_never = 1'b1;
    oq.push_back('{3'b010, 32'd0, 5'd0, 1'b0});
    do_op(1, 0, 3'b010, 32'h400, 32'd0, 5'd8, 1, 32'd0, 0, 0, 1, 32'd0, sn, lt);
    void'(oq.pop_back());
    check("to_stall_cycles", 32'(sn), 32'(TO + 1));
    check("to_err_latency", 32'(lt), 32'(TO + 1));
    repeat (6) begin @(posedge clk); #1; end
    rsp_never = 1'b0;
    check("to_req_dropped", 32'(bus.dbus_req), 32'd0);

    // Reset while waiting for the response
    gnt_dly = 0; rv_dly = 4; rsp_rdata = $urandom;
    bq.push_back('{32'h300, 1'b0, 4'b0001, 32'd0});
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_funct = 3'b000;
    result = 32'h300; rd_in = 5'd11; rd_we_in = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstwait_req", 32'(bus.dbus_req), 32'd0);
    check("rstwait_stall", 32'(mem_stall), 32'd0);
    repeat (8) @(posedge clk);
    #1;

    // LW at 0x101: misalign pulse when checking is built in, plain word access otherwise
    do_op(1, 0, 3'b010, 32'h101, 32'd0, 5'd12, 1, 32'hCAFE_F00D, 0, 0, 0, 32'd0, sn, lt);
    check("lw101_stall_cycles", 32'(sn), MIS_EN ? 32'd0 : 32'd2);
    check("lw101_latency", 32'(lt), MIS_EN ? 32'd1 : 32'd3);

    // Randomized ops
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 3);
      rdop = (k == 1 || k == 2);
      wrop = (k == 3);
      if (wrop) f = 3'($urandom_range(0, 2));
      else begin
        f = 3'($urandom_range(0, 4));
        if (f >= 3'd3) f = f + 3'd1;
      end
      a = $urandom;
      gd = $urandom_range(0, 2);
      rvd = $urandom_range(0, 2);
      mis = MIS_EN && (rdop || wrop) && exp_misal(f, a);
      do_op(rdop, wrop, f, a, $urandom, 5'($urandom), 1'($urandom), $urandom, gd, rvd, 0, 32'd0, sn, lt);
      check("rand_stall_cycles", 32'(sn), ((rdop || wrop) && !mis) ? 32'(2 + gd + rvd) : 32'd0);
    end

    repeat (10) @(posedge clk);
    check("out_queue_empty", 32'(oq.size()), 32'd0);
    check("bus_queue_empty", 32'(bq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the core pipeline, directly downstream of the execute stage. It takes the execute result (ALU sum, or effective address for loads/stores) and the store data, and runs one load or store at a time over a request/grant/response data bus. It stalls the pipeline while the access is outstanding and delivers aligned, sign- or zero-extended load data (or the passed-through ALU result) to writeback one cycle later.

## Interface
- `BUS_TIMEOUT`, default 255: cycles allowed in REQ+WAIT before the access is abandoned (1..1023).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_valid`  in  1  op present from EX/MEM register.
- `mem_read` / `mem_write`  in  1  load / store (never both high).
- `mem_funct`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `result`  in  `XLEN`  execute result / effective address.
- `rs2_data_out`  in  `XLEN`  store data.
- `rd_in`, `rd_we_in`  in  5 / 1  destination register and write-enable.
- `mem_stall`  out  1  hold upstream stages.
- `dbus_req`, `dbus_we`  out  1  bus request, write strobe.
- `dbus_addr`  out  `XLEN`  word-aligned (bits[1:0]=0).
- `dbus_wdata`  out  `XLEN`; `dbus_be`  out  4  byte enables.
- `dbus_gnt`, `dbus_rvalid`  in  1; `dbus_rdata`  in  `XLEN`.
- `wb_valid`, `wb_we`  out  1; `wb_rd`  out  5; `wb_data`  out  `XLEN`.
- `bus_err`, `misalign`  out  1  one-cycle error pulses.

## Operation
- FSM states IDLE, REQ, WAIT. Reset: state IDLE, every output 0.
- IDLE, `mem_valid` and neither read nor write: register `result` into `wb_data`, `rd_in`/`rd_we_in` into `wb_rd`/`wb_we`, `wb_valid`=1 next cycle; no stall.
- IDLE, load/store: latch addr, funct, lane data, rd; go to REQ; `mem_stall`=1 combinationally this cycle.
- REQ: `dbus_req`=1 with stable addr/we/be/wdata until `dbus_gnt`; on gnt go to WAIT (req drops next cycle).
- WAIT: on `dbus_rvalid` go to IDLE; a load registers extended data into `wb_data` with `wb_valid`=1; a store produces `wb_valid`=0.
- `mem_stall` = (IDLE & mem_valid & (read|write)) | REQ | (WAIT & !dbus_rvalid).
- Byte enables: B/BU `4'b0001<<addr[1:0]`; H/HU `4'b0011<<{addr[1],1'b0}`; W `4'b1111`. Store data replicated: B `{4{b}}`, H `{2{h}}`.
- Load extract: select lane by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend.
- Timeout: counter cleared on leaving IDLE, increments each REQ/WAIT cycle; at `BUS_TIMEOUT` return to IDLE, pulse `bus_err`, `wb_valid`=0, drop `dbus_req`.
- `dbus_rvalid` outside WAIT (late response after timeout/reset) is ignored.
- `rst` in any state: next cycle IDLE, `dbus_req`=0, `mem_stall`=0, counter 0.

## Timing
- Load, gnt and rvalid at earliest: accept T; req T+1 with gnt; rvalid T+2; `wb_valid` T+3. `mem_stall` high T, T+1; low T+2.
- Non-memory op: `wb_valid` one cycle after acceptance, zero stall.
- `dbus_req` is a registered output; gnt in the first REQ cycle is legal.
- `bus_err`/`misalign` last exactly one cycle, aligned with where `wb_valid` would have been.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0, issues no bus request, no stall, pulses `misalign` next cycle with `wb_valid`=0.
- Undefined: `misalign` tied 0; word access ignores addr[1:0], halfword ignores addr[0]; access proceeds normally.

## Test plan
- LW addr 0x100, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF -> `wb_data`=0xDEADBEEF, `wb_valid` at T+3, `mem_stall` high exactly 2 cycles.
- LB addr 0x103, rdata 0x80FF_0000 -> `wb_data`=0xFFFF_FF80; LBU same -> 0x0000_0080; LHU addr 0x102 -> 0x0000_80FF.
- SH addr 0x206, data 0x1234_ABCD, gnt delayed 3 cycles -> `dbus_be`=4'b1100, `dbus_wdata`=0xABCD_ABCD held stable until gnt, `wb_valid` stays 0.
- ALU op result 0x55, rd 7 -> `wb_data`=0x55, `wb_rd`=7, `wb_valid` next cycle, `mem_stall` never high.
- `BUS_TIMEOUT`=4, rvalid never arrives -> `bus_err` pulse after 4 REQ/WAIT cycles, FSM IDLE, later rvalid ignored.
- `rst` asserted in WAIT -> IDLE and `dbus_req`=0 next cycle; with `MEM_MISALIGN_CHECK_EN`, LW addr 0x101 -> `misalign` pulse, no `dbus_req`.
